// File: rtl/cache_pkg.sv
// ------------------------------------------------------------------
// cache_pkg: geometry, derived widths and controller state shared
// with drrip_cache.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package cache_pkg;

  localparam int NUM_WAYS   = 16;
  localparam int NUM_SETS   = 128;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_BYTES = 64;

  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_WIDTH - SET_W - OFF_W;
  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MISS_WAIT = 2'd2,
    RESP      = 2'd3
  } ctrl_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_tag_match.sv
// ------------------------------------------------------------------
// cache_tag_match: parallel tag compare over one set, lowest way wins.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cache_tag_match
  import cache_pkg::*;
(
  input  logic [NUM_WAYS-1:0]            valid_i,
  input  logic [NUM_WAYS-1:0][TAG_W-1:0] tags_i,
  input  logic [TAG_W-1:0]               tag_i,
  output logic                           hit_o,
  output logic [WAY_W-1:0]               hit_way_o
);

  // Scanning downwards lets the last assignment, the lowest way, win.
  always_comb begin
    hit_o     = 1'b0;
    hit_way_o = '0;
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      if (valid_i[k] && (tags_i[k] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_tag_ctrl.sv
// ------------------------------------------------------------------
// cache_tag_ctrl: tag lookup and miss handling directly upstream of
// drrip_cache.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module cache_tag_ctrl
  import cache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [WAY_W-1:0]      rsp_way,
  output logic                  rsp_evict_valid,
  output logic [TAG_W-1:0]      rsp_evict_tag,
  output logic                  rsp_err,
  output logic                  repl_valid,
  output logic [SET_W-1:0]      repl_set_index,
  output logic [WAY_W-1:0]      repl_access_way,
  output logic                  repl_hit,
  output logic                  repl_miss,
  input  logic [WAY_W-1:0]      repl_victim_way,
  input  logic                  repl_victim_ready,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t state_q, state_d;

  logic [SET_W-1:0] set_q, set_d;
  logic [TAG_W-1:0] req_tag_q, req_tag_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic             rsp_hit_q, rsp_hit_d;
  logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
  logic             rsp_ev_q, rsp_ev_d;
  logic [TAG_W-1:0] rsp_etag_q, rsp_etag_d;
  logic             rsp_err_q, rsp_err_d;
  logic             repl_hit_q, repl_hit_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0][TAG_W-1:0] tags_q  [NUM_SETS];

  logic [NUM_WAYS-1:0]            w_row_valid;
  logic [NUM_WAYS-1:0][TAG_W-1:0] w_row_tags;
  logic                           w_hit;
  logic [WAY_W-1:0]               w_hit_way;
  logic                           w_victim_valid;
  logic [TAG_W-1:0]               w_victim_tag;
  logic                           w_fill;
  logic                           w_req_ready;
  logic                           w_miss_req;
  logic                           w_unused;

  assign w_row_valid    = valid_q[set_q];
  assign w_row_tags     = tags_q[set_q];
  assign w_victim_valid = w_row_valid[repl_victim_way];
  assign w_victim_tag   = w_row_tags[repl_victim_way];
  assign w_unused       = ^req_addr[OFF_W-1:0];

  cache_tag_match u_match (
    .valid_i   (w_row_valid),
    .tags_i    (w_row_tags),
    .tag_i     (req_tag_q),
    .hit_o     (w_hit),
    .hit_way_o (w_hit_way)
  );

  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    req_tag_d   = req_tag_q;
    tmo_d       = tmo_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_way_d   = rsp_way_q;
    rsp_ev_d    = rsp_ev_q;
    rsp_etag_d  = rsp_etag_q;
    rsp_err_d   = rsp_err_q;
    repl_hit_d  = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    w_fill      = 1'b0;
    w_req_ready = 1'b0;
    w_miss_req  = 1'b0;

    case (state_q)
      IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          set_d     = req_addr[OFF_W +: SET_W];
          req_tag_d = req_addr[ADDR_WIDTH-1 -: TAG_W];
          state_d   = LOOKUP;
        end
      end

      LOOKUP: begin
        if (w_hit) begin
          state_d    = RESP;
          rsp_hit_d  = 1'b1;
          rsp_way_d  = w_hit_way;
          rsp_ev_d   = 1'b0;
          rsp_etag_d = '0;
          rsp_err_d  = 1'b0;
          repl_hit_d = 1'b1;
          hit_cnt_d  = sat_inc(hit_cnt_q);
        end else begin
          state_d    = MISS_WAIT;
          tmo_d      = '0;
          miss_cnt_d = sat_inc(miss_cnt_q);
        end
      end

      MISS_WAIT: begin
        // The miss request drops in the same cycle the victim arrives so
        // the replacement engine sees a single request per miss.
        if (repl_victim_ready) begin
          w_fill     = 1'b1;
          state_d    = RESP;
          rsp_hit_d  = 1'b0;
          rsp_way_d  = repl_victim_way;
          rsp_ev_d   = w_victim_valid;
          rsp_etag_d = w_victim_valid ? w_victim_tag : '0;
          rsp_err_d  = 1'b0;
        end else begin
          w_miss_req = 1'b1;
          if (tmo_q == TMO_LAST) begin
            state_d    = RESP;
            rsp_hit_d  = 1'b0;
            rsp_way_d  = '0;
            rsp_ev_d   = 1'b0;
            rsp_etag_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      set_q      <= '0;
      req_tag_q  <= '0;
      tmo_q      <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_way_q  <= '0;
      rsp_ev_q   <= 1'b0;
      rsp_etag_q <= '0;
      rsp_err_q  <= 1'b0;
      repl_hit_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      req_tag_q  <= req_tag_d;
      tmo_q      <= tmo_d;
      rsp_hit_q  <= rsp_hit_d;
      rsp_way_q  <= rsp_way_d;
      rsp_ev_q   <= rsp_ev_d;
      rsp_etag_q <= rsp_etag_d;
      rsp_err_q  <= rsp_err_d;
      repl_hit_q <= repl_hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (w_fill) begin
        valid_q[set_q][repl_victim_way] <= 1'b1;
      end
    end
  end

  // Tag storage carries no reset; valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      tags_q[set_q][repl_victim_way] <= req_tag_q;
    end
  end

  assign req_ready       = w_req_ready;
  assign rsp_valid       = (state_q == RESP);
  assign rsp_hit         = rsp_hit_q;
  assign rsp_way         = rsp_way_q;
  assign rsp_evict_valid = rsp_ev_q;
  assign rsp_evict_tag   = rsp_etag_q;
  assign rsp_err         = rsp_err_q;
  assign repl_valid      = w_miss_req | repl_hit_q;
  assign repl_miss       = w_miss_req;
  assign repl_hit        = repl_hit_q;
  assign repl_access_way = repl_hit_q ? rsp_way_q : '0;
  assign repl_set_index  = set_q;
  assign hit_cnt         = hit_cnt_q;
  assign miss_cnt        = miss_cnt_q;

endmodule

`default_nettype wire
